// File: rtl/lipsi_program_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : lipsi_program_loader_if
//  Purpose  : Instruction-memory write bus between the loader and the 256x8 RAM.
//  Revision : 1.0 - initial release
// ============================================================================
interface lipsi_program_loader_if;
    logic       imem_we;
    logic [7:0] imem_addr;
    logic [7:0] imem_wdata;

    modport master (output imem_we, output imem_addr, output imem_wdata);
    modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);
endinterface
`default_nettype wire

// File: rtl/lipsi_program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : lipsi_program_loader
//  Purpose  : UART (8N1) framed program loader writing Lipsi instruction memory.
//  Revision : 1.0 - initial release
// ============================================================================
module lipsi_program_loader #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_i,
    lipsi_program_loader_if.master        imem,
    output logic                          cpu_hold_o,
    output logic                          load_done_o,
    output logic                          load_error_o,
    output logic                          busy_o
);

    localparam logic [15:0] c_CNT_FULL = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] c_CNT_HALF = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0]  c_HEADER   = 8'hA5;

    localparam logic [1:0] c_RX_IDLE  = 2'd0;
    localparam logic [1:0] c_RX_START = 2'd1;
    localparam logic [1:0] c_RX_DATA  = 2'd2;
    localparam logic [1:0] c_RX_STOP  = 2'd3;

    localparam logic [1:0] c_FR_HUNT = 2'd0;
    localparam logic [1:0] c_FR_LEN  = 2'd1;
    localparam logic [1:0] c_FR_DATA = 2'd2;
    localparam logic [1:0] c_FR_CSUM = 2'd3;

    // ------------------------------------------------------------------
    // Bit receiver
    // ------------------------------------------------------------------
    logic        rx_meta_q, rx_sync_q;
    logic [1:0]  rx_state_q, rx_state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        byte_valid_q, byte_valid_d;
    logic        frame_err_q, frame_err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_state_q   <= c_RX_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= rx_i;
            rx_sync_q    <= rx_meta_q;
            rx_state_q   <= rx_state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        unique case (rx_state_q)
            c_RX_IDLE:  if (!rx_sync_q) rx_state_d = c_RX_START;
            c_RX_START: if (cnt_q == c_CNT_HALF) rx_state_d = rx_sync_q ? c_RX_IDLE : c_RX_DATA;
            c_RX_DATA:  if (cnt_q == c_CNT_FULL && bit_idx_q == 3'd7) rx_state_d = c_RX_STOP;
            c_RX_STOP:  if (cnt_q == c_CNT_FULL) rx_state_d = c_RX_IDLE;
            default:    rx_state_d = c_RX_IDLE;
        endcase
    end

    // Counter restarts at each sample point so every later sample lands mid-bit
    always_comb begin
        cnt_d        = cnt_q + 16'd1;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        unique case (rx_state_q)
            c_RX_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
            end
            c_RX_START: begin
                if (cnt_q == c_CNT_HALF) cnt_d = '0;
            end
            c_RX_DATA: begin
                if (cnt_q == c_CNT_FULL) begin
                    cnt_d     = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            c_RX_STOP: begin
                if (cnt_q == c_CNT_FULL) begin
                    cnt_d        = '0;
                    byte_valid_d = rx_sync_q;
                    frame_err_d  = !rx_sync_q;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    logic [1:0] fr_state_q, fr_state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] wr_cnt_q, wr_cnt_d;
    logic [7:0] sum_q, sum_d;
    logic       we_q, we_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       hold_q, hold_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;

    logic w_header, w_abort, w_success, w_last;

    assign w_header  = byte_valid_q && (fr_state_q == c_FR_HUNT) && (shift_q == c_HEADER);
    assign w_success = byte_valid_q && (fr_state_q == c_FR_CSUM) && (shift_q == sum_q);
    assign w_abort   = (fr_state_q != c_FR_HUNT) &&
                       (frame_err_q ||
                        (byte_valid_q && (fr_state_q == c_FR_LEN)  && (shift_q == 8'd0)) ||
                        (byte_valid_q && (fr_state_q == c_FR_CSUM) && (shift_q != sum_q)));
    assign w_last    = ((wr_cnt_q + 8'd1) == len_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fr_state_q <= c_FR_HUNT;
            len_q      <= '0;
            wr_cnt_q   <= '0;
            sum_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            fr_state_q <= fr_state_d;
            len_q      <= len_d;
            wr_cnt_q   <= wr_cnt_d;
            sum_q      <= sum_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        fr_state_d = fr_state_q;
        if (w_abort || w_success) begin
            fr_state_d = c_FR_HUNT;
        end else if (w_header) begin
            fr_state_d = c_FR_LEN;
        end else if (byte_valid_q) begin
            unique case (fr_state_q)
                c_FR_LEN:  fr_state_d = c_FR_DATA;
                c_FR_DATA: if (w_last) fr_state_d = c_FR_CSUM;
                default:   fr_state_d = fr_state_q;
            endcase
        end
    end

    always_comb begin
        len_d    = len_q;
        wr_cnt_d = wr_cnt_q;
        sum_d    = sum_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        hold_d   = hold_q;
        done_d   = done_q;
        err_d    = err_q;
        busy_d   = busy_q;
        if (w_abort) begin
            err_d  = 1'b1;
            done_d = 1'b0;
            hold_d = 1'b1;
            busy_d = 1'b0;
        end else if (w_success) begin
            done_d = 1'b1;
            hold_d = 1'b0;
            busy_d = 1'b0;
        end else if (w_header) begin
            hold_d   = 1'b1;
            busy_d   = 1'b1;
            done_d   = 1'b0;
            err_d    = 1'b0;
            sum_d    = '0;
            wr_cnt_d = '0;
        end else if (byte_valid_q && fr_state_q == c_FR_LEN) begin
            len_d = shift_q;
        end else if (byte_valid_q && fr_state_q == c_FR_DATA) begin
            we_d     = 1'b1;
            addr_d   = wr_cnt_q;
            wdata_d  = shift_q;
            sum_d    = sum_q + shift_q;
            wr_cnt_d = wr_cnt_q + 8'd1;
        end
    end

    assign imem.imem_we    = we_q;
    assign imem.imem_addr  = addr_q;
    assign imem.imem_wdata = wdata_q;
    assign cpu_hold_o      = hold_q;
    assign load_done_o     = done_q;
    assign load_error_o    = err_q;
    assign busy_o          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_lipsi_program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lipsi_program_loader
//  Purpose  : Scoreboard bench for the UART program loader (CLKS_PER_BIT=16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lipsi_program_loader;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic reset;
    logic rx;
    logic cpu_hold, load_done, load_error, busy;

    lipsi_program_loader_if imem ();

    lipsi_program_loader #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_i         (rx),
        .imem         (imem.master),
        .cpu_hold_o   (cpu_hold),
        .load_done_o  (load_done),
        .load_error_o (load_error),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_writes = 0;
    logic [15:0] sb[$];

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Every write must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (imem.imem_we === 1'b1) begin
            n_writes++;
            if (sb.size() == 0) begin
                check_value("unexpected_write", {imem.imem_addr, imem.imem_wdata}, 32'hFFFF_FFFF);
            end else begin
                logic [15:0] e;
                e = sb.pop_front();
                check_value("write_addr", imem.imem_addr, e[15:8]);
                check_value("write_data", imem.imem_wdata, e[7:0]);
            end
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic exp_write(input logic [7:0] a, input logic [7:0] d);
        sb.push_back({a, d});
    endtask

    task automatic check_status(input string tag, input logic done, input logic err,
                                input logic hold, input logic bsy);
        check_value({tag, ".load_done"},  load_done,  done);
        check_value({tag, ".load_error"}, load_error, err);
        check_value({tag, ".cpu_hold"},   cpu_hold,   hold);
        check_value({tag, ".busy"},       busy,       bsy);
    endtask

    int base;

    initial begin
        rx    = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_value("rst.imem_we",    imem.imem_we,    0);
        check_value("rst.imem_addr",  imem.imem_addr,  0);
        check_value("rst.imem_wdata", imem.imem_wdata, 0);
        check_status("rst", 0, 0, 1, 0);
        reset = 1'b0;
        idle(20);

        // Good 3-byte frame, bytes sent back to back
        base = n_writes;
        send_byte(8'hA5, 1'b1);
        idle(2);
        check_status("t1_hdr", 0, 0, 1, 1);
        send_byte(8'h03, 1'b1);
        exp_write(8'd0, 8'hC7); send_byte(8'hC7, 1'b1);
        exp_write(8'd1, 8'h05); send_byte(8'h05, 1'b1);
        exp_write(8'd2, 8'hFF); send_byte(8'hFF, 1'b1);
        send_byte(8'hCB, 1'b1);
        idle(4);
        check_value("t1.writes", n_writes - base, 3);
        check_value("t1.pending", sb.size(), 0);
        check_status("t1", 1, 0, 0, 0);

        // Bad checksum
        base = n_writes;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        exp_write(8'd0, 8'hC7); send_byte(8'hC7, 1'b1);
        exp_write(8'd1, 8'h0F); send_byte(8'h0F, 1'b1);
        send_byte(8'h00, 1'b1);
        idle(4);
        check_value("t2.writes", n_writes - base, 2);
        check_status("t2", 0, 1, 1, 0);

        // Junk prefix then a 1-byte frame
        base = n_writes;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h12, 1'b1);
        idle(4);
        check_value("t3.prefix_writes", n_writes - base, 0);
        check_status("t3_prefix", 0, 1, 1, 0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        exp_write(8'd0, 8'hFF); send_byte(8'hFF, 1'b1);
        send_byte(8'hFF, 1'b1);
        idle(4);
        check_value("t3.writes", n_writes - base, 1);
        check_status("t3", 1, 0, 0, 0);

        // Zero length, then recovery
        base = n_writes;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        idle(4);
        check_value("t4_len0.writes", n_writes - base, 0);
        check_status("t4_len0", 0, 1, 1, 0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        exp_write(8'd0, 8'h07); send_byte(8'h07, 1'b1);
        send_byte(8'h07, 1'b1);
        idle(4);
        check_value("t4.writes", n_writes - base, 1);
        check_status("t4", 1, 0, 0, 0);

        // Start-bit glitch, then framing error on the second data byte
        base = n_writes;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(12 * CPB);
        check_value("t5_glitch.writes", n_writes - base, 0);
        check_status("t5_glitch", 1, 0, 0, 0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        exp_write(8'd0, 8'h11); send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        idle(12 * CPB);
        check_value("t5.writes", n_writes - base, 1);
        check_status("t5", 0, 1, 1, 0);

        // Successful load, then reset in the middle of the next frame
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        exp_write(8'd0, 8'hC7); send_byte(8'hC7, 1'b1);
        send_byte(8'hC7, 1'b1);
        idle(4);
        check_status("t6_pre", 1, 0, 0, 0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        exp_write(8'd0, 8'h10); send_byte(8'h10, 1'b1);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = 1'b1;
            repeat (CPB) @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        check_value("t6_rst.imem_we",    imem.imem_we,    0);
        check_value("t6_rst.imem_wdata", imem.imem_wdata, 0);
        check_value("t6_rst.imem_addr",  imem.imem_addr,  0);
        check_status("t6_rst", 0, 0, 1, 0);
        repeat (2) @(negedge clk);
        rx    = 1'b1;
        reset = 1'b0;
        base  = n_writes;
        idle(12 * CPB);
        check_value("t6_after_rst.writes", n_writes - base, 0);
        check_status("t6_after_rst", 0, 0, 1, 0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        exp_write(8'd0, 8'hFF); send_byte(8'hFF, 1'b1);
        send_byte(8'hFF, 1'b1);
        idle(4);
        check_value("t6.writes", n_writes - base, 1);
        check_status("t6", 1, 0, 0, 0);
        check_value("final.pending", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
